// File: rtl/halut_pkg.sv
// Shared HALUT constants and types used by the encoder output and the decoder input.
package halut_pkg;

  localparam int unsigned K             = 16;
  localparam int unsigned C             = 32;
  localparam int unsigned DataTypeWidth = 16;
  localparam int unsigned RowCntWidth   = 16;
  localparam int unsigned TreeDepth     = $clog2(K);
  localparam int unsigned CAddrWidth    = $clog2(C);
  localparam int unsigned LutAddrWidth  = CAddrWidth + TreeDepth;
  localparam int unsigned DecAccWidth   = DataTypeWidth + $clog2(C);

  typedef struct packed {
    logic [CAddrWidth-1:0] c;
    logic [TreeDepth-1:0]  k;
  } lut_addr_t;

  typedef logic signed [DecAccWidth-1:0] acc_t;

  function automatic acc_t sext(input logic [DataTypeWidth-1:0] v);
    return {{(DecAccWidth-DataTypeWidth){v[DataTypeWidth-1]}}, v};
  endfunction

endpackage

// File: rtl/halut_decoder_if.sv
// LUT preload port, encoder term stream and row-result outputs of one decoder column.
interface halut_decoder_if;
  import halut_pkg::*;

  logic [LutAddrWidth-1:0]  waddr_i;
  logic [DataTypeWidth-1:0] wdata_i;
  logic                     we_i;
  logic                     decoder_i;
  logic [CAddrWidth-1:0]    c_addr_i;
  logic [TreeDepth-1:0]     k_addr_i;
  logic                     valid_i;
  logic [DecAccWidth-1:0]   result_o;
  logic [RowCntWidth-1:0]   row_o;
  logic                     valid_o;
  logic                     err_o;

  modport master (
    output waddr_i, wdata_i, we_i, decoder_i, c_addr_i, k_addr_i, valid_i,
    input  result_o, row_o, valid_o, err_o
  );

  modport slave (
    input  waddr_i, wdata_i, we_i, decoder_i, c_addr_i, k_addr_i, valid_i,
    output result_o, row_o, valid_o, err_o
  );

endinterface

// File: rtl/halut_decoder_lut.sv
// Register-file LUT: synchronous write, combinational read (same-cycle read sees old data).
module halut_decoder_lut #(
  parameter int unsigned Depth     = 512,
  parameter int unsigned Width     = 16,
  parameter int unsigned AddrWidth = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/halut_decoder.sv
// HALUT decoder column: registers encoder terms, looks up LUT entries and sums C terms per row.
module halut_decoder #(
  parameter int unsigned K             = halut_pkg::K,
  parameter int unsigned C             = halut_pkg::C,
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter int unsigned RowCntWidth   = halut_pkg::RowCntWidth
) (
  input logic           clk_i,
  input logic           rst_i,
  halut_decoder_if.slave dec
);
  import halut_pkg::*;

  localparam int unsigned TreeDepth    = $clog2(K);
  localparam int unsigned CAddrWidth   = $clog2(C);
  localparam int unsigned LutAddrWidth = CAddrWidth + TreeDepth;

  typedef enum logic {IDLE, ACC} state_e;

  state_e                   state_q, state_d;
  logic                     valid_q, valid_d;
  lut_addr_t                addr_q, addr_d;
  logic [CAddrWidth-1:0]    term_q, term_d;
  logic [C-1:0]             seen_q, seen_d;
  acc_t                     acc_q, acc_d, sum;
  acc_t                     result_q, result_d;
  logic [RowCntWidth-1:0]   row_cnt_q, row_cnt_d, row_q, row_d;
  logic                     done_q, done_d, err_q, err_d;
  logic [DataTypeWidth-1:0] rdata;

  halut_decoder_lut #(
    .Depth    (C * K),
    .Width    (DataTypeWidth),
    .AddrWidth(LutAddrWidth)
  ) u_lut (
    .clk  (clk_i),
    .rst  (rst_i),
    .we   (dec.we_i),
    .waddr(dec.waddr_i),
    .wdata(dec.wdata_i),
    .raddr(addr_q),
    .rdata(rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      term_q    <= '0;
      seen_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      row_cnt_q <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      term_q    <= term_d;
      seen_q    <= seen_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      row_cnt_q <= row_cnt_d;
      row_q     <= row_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = dec.decoder_i ? ACC : IDLE;
    valid_d   = dec.decoder_i & dec.valid_i;
    addr_d    = '0;
    term_d    = term_q;
    seen_d    = seen_q;
    acc_d     = acc_q;
    result_d  = result_q;
    row_cnt_d = row_cnt_q;
    row_d     = row_q;
    done_d    = 1'b0;
    err_d     = err_q;
    sum       = acc_q + sext(rdata);

    if (dec.decoder_i) begin
      addr_d.c = dec.c_addr_i;
      addr_d.k = dec.k_addr_i;
    end

    if (!dec.decoder_i) begin
      term_d    = '0;
      seen_d    = '0;
      acc_d     = '0;
      result_d  = '0;
      row_cnt_d = '0;
      row_d     = '0;
      err_d     = 1'b0;
    end else if (state_q == ACC && valid_q) begin
      if (seen_q[addr_q.c]) err_d = 1'b1;
      // Last term closes the row and clears per-row state so the next term starts a fresh row.
      if (term_q == CAddrWidth'(C - 1)) begin
        result_d  = sum;
        done_d    = 1'b1;
        row_d     = row_cnt_q;
        row_cnt_d = row_cnt_q + RowCntWidth'(1);
        acc_d     = '0;
        term_d    = '0;
        seen_d    = '0;
      end else begin
        acc_d            = sum;
        term_d           = term_q + CAddrWidth'(1);
        seen_d[addr_q.c] = 1'b1;
      end
    end
  end

  assign dec.result_o = result_q;
  assign dec.row_o    = row_q;
  assign dec.valid_o  = done_q;
  assign dec.err_o    = err_q;

endmodule

// File: tb/tb_halut_decoder.sv
// Directed bench for halut_decoder: row sums, latency, back-to-back rows, duplicates, clears, collisions.
module tb_halut_decoder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  halut_decoder_if dif ();

  halut_decoder dut (
    .clk_i(clk),
    .rst_i(rst),
    .dec  (dif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: c+1, 1: -32768, 2: k, 3: 1
  task automatic preload(input int mode);
    logic [4:0]  c5;
    logic [3:0]  k4;
    logic [15:0] d;
    for (int c = 0; c < 32; c++) begin
      for (int k = 0; k < 16; k++) begin
        c5 = 5'(c);
        k4 = 4'(k);
        case (mode)
          0:       d = 16'(c + 1);
          1:       d = 16'h8000;
          2:       d = 16'(k);
          default: d = 16'd1;
        endcase
        dif.we_i    = 1'b1;
        dif.waddr_i = {c5, k4};
        dif.wdata_i = d;
        tick();
      end
    end
    dif.we_i = 1'b0;
  endtask

  task automatic send(input int c, input int k);
    dif.valid_i  = 1'b1;
    dif.c_addr_i = 5'(c);
    dif.k_addr_i = 4'(k);
    tick();
  endtask

  task automatic dec_off();
    dif.valid_i   = 1'b0;
    dif.decoder_i = 1'b0;
    tick();
    dif.decoder_i = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    dif.we_i      = 1'b0;
    dif.waddr_i   = '0;
    dif.wdata_i   = '0;
    dif.decoder_i = 1'b0;
    dif.valid_i   = 1'b0;
    dif.c_addr_i  = '0;
    dif.k_addr_i  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_result", $signed(dif.result_o), 0);
    chk("reset_row", dif.row_o, 0);
    chk("reset_valid", dif.valid_o, 0);
    chk("reset_err", dif.err_o, 0);

    // Row sum 1..32 and two-cycle latency
    preload(0);
    dif.decoder_i = 1'b1;
    for (int i = 0; i < 32; i++) send(i, i % 16);
    dif.valid_i = 1'b0;
    chk("sum_early_valid", dif.valid_o, 0);
    tick();
    chk("sum_valid", dif.valid_o, 1);
    chk("sum_result", $signed(dif.result_o), 528);
    chk("sum_row", dif.row_o, 0);
    chk("sum_err", dif.err_o, 0);
    tick();
    chk("sum_pulse_end", dif.valid_o, 0);
    chk("sum_hold", $signed(dif.result_o), 528);

    dec_off();
    chk("off_clears_result", $signed(dif.result_o), 0);

    // Most-negative entries
    preload(1);
    for (int i = 0; i < 32; i++) send(i, 7);
    dif.valid_i = 1'b0;
    tick();
    chk("neg_valid", dif.valid_o, 1);
    chk("neg_result", $signed(dif.result_o), -1048576);

    // Back-to-back rows
    dec_off();
    preload(2);
    for (int i = 0; i < 64; i++) begin
      send(i % 32, (i < 32) ? 1 : 2);
      if (i == 32) begin
        chk("b2b_valid0", dif.valid_o, 1);
        chk("b2b_result0", $signed(dif.result_o), 32);
        chk("b2b_row0", dif.row_o, 0);
      end
      if (i == 33) chk("b2b_pulse0_end", dif.valid_o, 0);
    end
    dif.valid_i = 1'b0;
    chk("b2b_no_early", dif.valid_o, 0);
    tick();
    chk("b2b_valid1", dif.valid_o, 1);
    chk("b2b_result1", $signed(dif.result_o), 64);
    chk("b2b_row1", dif.row_o, 1);

    // Duplicate c=5 at term index 10
    dec_off();
    for (int i = 0; i < 32; i++) begin
      send((i < 10) ? i : ((i == 10) ? 5 : i - 1), 1);
      if (i == 10) chk("dup_err_not_yet", dif.err_o, 0);
      if (i == 11) chk("dup_err_set", dif.err_o, 1);
    end
    dif.valid_i = 1'b0;
    chk("dup_err_sticky", dif.err_o, 1);
    tick();
    chk("dup_valid", dif.valid_o, 1);
    chk("dup_result", $signed(dif.result_o), 32);
    chk("dup_row", dif.row_o, 0);
    chk("dup_err_after", dif.err_o, 1);

    // Partial row discarded by decoder_i drop
    dec_off();
    preload(3);
    for (int i = 0; i < 10; i++) send(i % 5, 0);
    dif.valid_i = 1'b0;
    tick();
    chk("partial_err", dif.err_o, 1);
    dec_off();
    chk("drop_err_clear", dif.err_o, 0);
    chk("drop_no_valid", dif.valid_o, 0);
    for (int i = 0; i < 32; i++) send(i, 4);
    dif.valid_i = 1'b0;
    chk("fresh_no_early", dif.valid_o, 0);
    tick();
    chk("fresh_valid", dif.valid_o, 1);
    chk("fresh_result", $signed(dif.result_o), 32);
    chk("fresh_row", dif.row_o, 0);
    chk("fresh_err", dif.err_o, 0);

    // Write/read collision on LUT[0,3]
    dif.we_i    = 1'b1;
    dif.waddr_i = {5'd0, 4'd3};
    dif.wdata_i = 16'd2;
    tick();
    dif.we_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 1) begin
        dif.we_i    = 1'b1;
        dif.waddr_i = {5'd0, 4'd3};
        dif.wdata_i = 16'd7;
      end else begin
        dif.we_i = 1'b0;
      end
      send(i, 3);
    end
    dif.we_i    = 1'b0;
    dif.valid_i = 1'b0;
    tick();
    chk("coll_old_result", $signed(dif.result_o), 33);
    chk("coll_old_row", dif.row_o, 1);
    for (int i = 0; i < 32; i++) send(i, 3);
    dif.valid_i = 1'b0;
    tick();
    chk("coll_new_result", $signed(dif.result_o), 38);
    chk("coll_new_row", dif.row_o, 2);

    // Mid-row reset clears the LUT and partial state
    for (int i = 0; i < 5; i++) send(i, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_result", $signed(dif.result_o), 0);
    chk("rst_valid", dif.valid_o, 0);
    for (int i = 0; i < 32; i++) send(i, 3);
    dif.valid_i = 1'b0;
    tick();
    chk("rst_lut_valid", dif.valid_o, 1);
    chk("rst_lut_result", $signed(dif.result_o), 0);
    chk("rst_lut_row", dif.row_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
